// File: rtl/smem_responder_pkg.sv
// Shared types and geometry helpers for the shared-memory responder.
// Optional SMEM_PERF_EN adds a bank-conflict stall counter in the top.
package smem_responder_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_SERVE, ST_RSP} state_t;

   function automatic int rows_per_bank(input int smem_size, input int word_size,
                                        input int num_banks);
      return smem_size / (word_size * num_banks);
   endfunction

   localparam int DEF_NUM_THREADS = 4;
   localparam int DEF_NUM_BANKS   = 4;
   localparam int DEF_WORD_SIZE   = 4;
   localparam int DEF_SMEM_SIZE   = 16384;
   localparam int DEF_ADDR_WIDTH  = 30;
   localparam int DEF_TAG_WIDTH   = 8;
   localparam int DEF_ROWS        = rows_per_bank(DEF_SMEM_SIZE, DEF_WORD_SIZE, DEF_NUM_BANKS);
   localparam int DEF_BANK_W      = $clog2(DEF_NUM_BANKS);
   localparam int DEF_ROW_W       = $clog2(DEF_ROWS);

endpackage

// File: rtl/smem_responder_if.sv
// Per-lane request / merged response bus between the data-bus split and the responder.
interface smem_responder_if #(
   parameter int NUM_THREADS = 4,
   parameter int WORD_SIZE   = 4,
   parameter int ADDR_WIDTH  = 30,
   parameter int TAG_WIDTH   = 8
);
   logic [NUM_THREADS-1:0]                     req_valid;
   logic [NUM_THREADS-1:0]                     req_rw;
   logic [NUM_THREADS-1:0][WORD_SIZE-1:0]      req_byteen;
   logic [NUM_THREADS-1:0][ADDR_WIDTH-1:0]     req_addr;
   logic [NUM_THREADS-1:0][WORD_SIZE*8-1:0]    req_data;
   logic [NUM_THREADS-1:0][TAG_WIDTH-1:0]      req_tag;
   logic [NUM_THREADS-1:0]                     req_ready;
   logic [NUM_THREADS-1:0]                     rsp_valid;
   logic [NUM_THREADS-1:0][WORD_SIZE*8-1:0]    rsp_data;
   logic [TAG_WIDTH-1:0]                       rsp_tag;
   logic                                       rsp_ready;

   modport master (output req_valid, req_rw, req_byteen, req_addr, req_data, req_tag, rsp_ready,
                   input  req_ready, rsp_valid, rsp_data, rsp_tag);
   modport slave  (input  req_valid, req_rw, req_byteen, req_addr, req_data, req_tag, rsp_ready,
                   output req_ready, rsp_valid, rsp_data, rsp_tag);
endinterface

// File: rtl/smem_responder_bank.sv
// Single-port word bank with byte-enable write; read data is captured by the
// top into the requesting lane's response slot on the same edge, giving a registered read.
module smem_bank #(
   parameter int ROWS      = 1024,
   parameter int ROW_W     = 10,
   parameter int WORD_SIZE = 4
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [WORD_SIZE-1:0]   byteen,
   input  logic [ROW_W-1:0]       row,
   input  logic [WORD_SIZE*8-1:0] wdata,
   output logic [WORD_SIZE*8-1:0] rdata
);
   logic [WORD_SIZE-1:0][7:0] mem [ROWS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < WORD_SIZE; i++)
         if (we && byteen[i]) mem[row][i] <= wdata[i*8 +: 8];
   end

   assign rdata = mem[row];
endmodule

// File: rtl/smem_responder.sv
// Shared-memory responder: serializes bank conflicts, merges same-row reads,
// returns one read response per batch. SMEM_PERF_EN adds perf_bank_stalls.
module smem_responder
   import smem_responder_pkg::*;
#(
   parameter int NUM_THREADS = DEF_NUM_THREADS,
   parameter int NUM_BANKS   = DEF_NUM_BANKS,
   parameter int WORD_SIZE   = DEF_WORD_SIZE,
   parameter int SMEM_SIZE   = DEF_SMEM_SIZE,
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int TAG_WIDTH   = DEF_TAG_WIDTH
) (
   input logic             clk,
   input logic             reset,
   smem_responder_if.slave bus
`ifdef SMEM_PERF_EN
   ,
   output logic [43:0]     perf_bank_stalls
`endif
);
   localparam int ROWS   = rows_per_bank(SMEM_SIZE, WORD_SIZE, NUM_BANKS);
   localparam int BANK_W = $clog2(NUM_BANKS);
   localparam int ROW_W  = $clog2(ROWS);
   localparam int DW     = WORD_SIZE * 8;

   state_t state, state_nxt;
   logic [NUM_THREADS-1:0]                 pending, rd_mask, served;
   logic [NUM_THREADS-1:0]                 lane_rw;
   logic [NUM_THREADS-1:0][WORD_SIZE-1:0]  lane_be;
   logic [NUM_THREADS-1:0][BANK_W-1:0]     lane_bank;
   logic [NUM_THREADS-1:0][ROW_W-1:0]      lane_row;
   logic [NUM_THREADS-1:0][DW-1:0]         lane_wd, rsp_data_q;
   logic [NUM_THREADS-1:0][TAG_WIDTH-1:0]  lane_tag;

   logic [NUM_BANKS-1:0]                   bank_we;
   logic [NUM_BANKS-1:0][ROW_W-1:0]        bank_row;
   logic [NUM_BANKS-1:0][WORD_SIZE-1:0]    bank_be;
   logic [NUM_BANKS-1:0][DW-1:0]           bank_wd, bank_rdata;

   wire accept = (state == ST_IDLE) && (|bus.req_valid);

   // Per bank: lowest pending lane wins; a winning read also takes every
   // pending read to the same row, a winning write goes alone.
   always_comb begin
      served   = '0;
      bank_we  = '0;
      bank_row = '0;
      bank_be  = '0;
      bank_wd  = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         logic                   found, sel_rw;
         logic [ROW_W-1:0]       sel_row;
         logic [WORD_SIZE-1:0]   sel_be;
         logic [DW-1:0]          sel_wd;
         logic [NUM_THREADS-1:0] sel_hot;
         found = 1'b0; sel_rw = 1'b0; sel_row = '0; sel_be = '0; sel_wd = '0; sel_hot = '0;
         for (int l = 0; l < NUM_THREADS; l++)
            if (!found && pending[l] && lane_bank[l] == BANK_W'(b)) begin
               found = 1'b1; sel_rw = lane_rw[l]; sel_row = lane_row[l];
               sel_be = lane_be[l]; sel_wd = lane_wd[l]; sel_hot[l] = 1'b1;
            end
         bank_row[b] = sel_row;
         if (found && sel_rw) begin
            bank_we[b] = !reset;
            bank_be[b] = sel_be;
            bank_wd[b] = sel_wd;
            served     = served | sel_hot;
         end else if (found) begin
            for (int l = 0; l < NUM_THREADS; l++)
               if (pending[l] && !lane_rw[l] && lane_bank[l] == BANK_W'(b) && lane_row[l] == sel_row)
                  served[l] = 1'b1;
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      smem_bank #(.ROWS(ROWS), .ROW_W(ROW_W), .WORD_SIZE(WORD_SIZE)) u_bank (
         .clk(clk), .we(bank_we[b]), .byteen(bank_be[b]), .row(bank_row[b]),
         .wdata(bank_wd[b]), .rdata(bank_rdata[b]));
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = ST_SERVE;
         ST_SERVE: if ((pending & ~served) == '0) state_nxt = (|rd_mask) ? ST_RSP : ST_IDLE;
         ST_RSP:   if (bus.rsp_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         pending    <= '0;
         rd_mask    <= '0;
         rsp_data_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            pending <= bus.req_valid;
            rd_mask <= bus.req_valid & ~bus.req_rw;
         end else if (state == ST_SERVE) begin
            pending <= pending & ~served;
            for (int l = 0; l < NUM_THREADS; l++)
               if (served[l] && !lane_rw[l]) rsp_data_q[l] <= bank_rdata[lane_bank[l]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lane_rw  <= bus.req_rw;
         lane_be  <= bus.req_byteen;
         lane_wd  <= bus.req_data;
         lane_tag <= bus.req_tag;
         for (int l = 0; l < NUM_THREADS; l++) begin
            lane_bank[l] <= bus.req_addr[l][BANK_W-1:0];
            lane_row[l]  <= bus.req_addr[l][BANK_W +: ROW_W];
         end
      end
   end

   always_comb begin
      bus.req_ready = {NUM_THREADS{state == ST_IDLE}};
      bus.rsp_valid = (state == ST_RSP) ? rd_mask : '0;
      bus.rsp_data  = rsp_data_q;
      bus.rsp_tag   = '0;
      if (state == ST_RSP)
         for (int l = NUM_THREADS - 1; l >= 0; l--)
            if (rd_mask[l]) bus.rsp_tag = lane_tag[l];
   end

`ifdef SMEM_PERF_EN
   logic serve_first;

   always_ff @(posedge clk) begin
      if (reset) begin
         serve_first      <= 1'b0;
         perf_bank_stalls <= '0;
      end else begin
         serve_first <= accept;
         if (state == ST_SERVE && !serve_first) perf_bank_stalls <= perf_bank_stalls + 44'd1;
      end
   end
`endif
endmodule

// File: tb/tb_smem_responder.sv
// Scoreboard bench for smem_responder: directed scenarios plus random batches
// checked against an address-level memory model.
module tb_smem_responder;
   logic clk, reset;
   int   total, bad, cyc;

   smem_responder_if #(.NUM_THREADS(4), .WORD_SIZE(4), .ADDR_WIDTH(30), .TAG_WIDTH(8)) bus ();
`ifdef SMEM_PERF_EN
   logic [43:0] perf;
`endif

   smem_responder dut (
      .clk(clk), .reset(reset), .bus(bus)
`ifdef SMEM_PERF_EN
      , .perf_bank_stalls(perf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0]        mask;
      logic [3:0][31:0]  data;
      logic [7:0]        tag;
      int                lat;
      int                t0;
      int                hold;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] mem_m [0:4095];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
      return r;
   endfunction

   // Monitor: checks the first beat of each response, then stability while held.
   exp_t             cur;
   logic             held;
   int               hold_left;
   logic [3:0]       snap_v;
   logic [7:0]       snap_t;
   logic [127:0]     snap_d;

   always @(negedge clk) begin
      if (reset) begin
         held = 1'b0;
         bus.rsp_ready = 1'b0;
      end else if (bus.rsp_valid != 4'd0) begin
         if (!held) begin
            held = 1'b1;
            snap_v = bus.rsp_valid; snap_t = bus.rsp_tag; snap_d = bus.rsp_data;
            if (sbq.size() == 0) begin
               chk("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
               hold_left = 0;
            end else begin
               cur = sbq.pop_front();
               chk("rsp_mask", 64'(bus.rsp_valid), 64'(cur.mask));
               chk("rsp_tag", 64'(bus.rsp_tag), 64'(cur.tag));
               chk("rsp_latency", 64'(cyc - cur.t0), 64'(cur.lat));
               for (int l = 0; l < 4; l++)
                  if (cur.mask[l]) chk($sformatf("rsp_data%0d", l), 64'(bus.rsp_data[l]), 64'(cur.data[l]));
               hold_left = cur.hold;
            end
         end else begin
            chk("hold_stable", {bus.rsp_valid, bus.rsp_tag, 52'(bus.rsp_data ^ snap_d)},
                {snap_v, snap_t, 52'd0});
            chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
         end
         if (hold_left > 0) begin
            hold_left--;
            bus.rsp_ready = 1'b0;
         end else bus.rsp_ready = 1'($urandom_range(0, 1));
         if (bus.rsp_ready) held = 1'b0;
      end else begin
         held = 1'b0;
         bus.rsp_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (bus.req_ready != 4'hF && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("req_ready_timeout", 64'(bus.req_ready), 64'hF);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sbq.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("drain_timeout", 64'(sbq.size()), 64'd0);
   endtask

   task automatic do_batch(input logic [3:0] v, input logic [3:0] rw,
                           input logic [3:0][3:0] be, input logic [3:0][29:0] ad,
                           input logic [3:0][31:0] wd, input logic [3:0][7:0] tg,
                           input int hold);
      exp_t       e;
      logic [3:0] rdm;
      int         maxc, seen, n;
      wait_ready();
      bus.req_valid = v; bus.req_rw = rw; bus.req_byteen = be;
      bus.req_addr = ad; bus.req_data = wd; bus.req_tag = tg;
      rdm = v & ~rw;
      e.mask = rdm; e.data = '0; e.tag = '0; e.t0 = cyc; e.hold = hold;
      for (int l = 3; l >= 0; l--) if (rdm[l]) e.tag = tg[l];
      // A read sees writes from lanes below the first read of its address.
      for (int l = 0; l < 4; l++) if (rdm[l]) begin
         int f = l;
         logic [31:0] val;
         for (int k = 3; k >= 0; k--) if (rdm[k] && ad[k][11:0] == ad[l][11:0]) f = k;
         val = mem_m[ad[l][11:0]];
         for (int w = 0; w < f; w++)
            if (v[w] && rw[w] && ad[w][11:0] == ad[l][11:0]) val = merge(val, wd[w], be[w]);
         e.data[l] = val;
      end
      // Access cycles per bank: one per write plus one per distinct read address.
      maxc = 0;
      for (int b = 0; b < 4; b++) begin
         int c = 0;
         for (int l = 0; l < 4; l++) if (v[l] && ad[l][1:0] == 2'(b)) begin
            if (rw[l]) c++;
            else begin
               logic dup = 1'b0;
               for (int k = 0; k < l; k++) if (rdm[k] && ad[k][11:0] == ad[l][11:0]) dup = 1'b1;
               if (!dup) c++;
            end
         end
         if (c > maxc) maxc = c;
      end
      e.lat = 1 + maxc;
      if (rdm != 4'd0) sbq.push_back(e);
      for (int l = 0; l < 4; l++)
         if (v[l] && rw[l]) mem_m[ad[l][11:0]] = merge(mem_m[ad[l][11:0]], wd[l], be[l]);
      @(negedge clk);
      bus.req_valid = 4'd0;
      if (rdm == 4'd0) begin
         seen = 0; n = 0;
         while (bus.req_ready != 4'hF && n < 50) begin
            if (bus.rsp_valid != 4'd0) seen = 1;
            @(negedge clk);
            n++;
         end
         chk("write_batch_no_rsp", 64'(seen), 64'd0);
      end
   endtask

   initial begin
      logic [3:0][31:0] wd;
      logic [3:0][29:0] ad;
      logic [3:0][3:0]  be;
      logic [3:0][7:0]  tg;
      logic [3:0]       v, rw;
`ifdef SMEM_PERF_EN
      logic [43:0]      p0;
`endif
      total = 0; bad = 0; cyc = 0;
      reset = 1'b1;
      bus.req_valid = '0; bus.req_rw = '0; bus.req_byteen = '0;
      bus.req_addr = '0; bus.req_data = '0; bus.req_tag = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_req_ready", 64'(bus.req_ready), 64'hF);
      chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("reset_rsp_tag", 64'(bus.rsp_tag), 64'd0);
      chk("reset_rsp_data", 64'(bus.rsp_data[0] | bus.rsp_data[1] | bus.rsp_data[2] | bus.rsp_data[3]), 64'd0);
`ifdef SMEM_PERF_EN
      chk("reset_perf", 64'(perf), 64'd0);
`endif

      // Preload word addresses 0..31.
      for (int a = 0; a < 32; a += 4) begin
         for (int l = 0; l < 4; l++) begin
            ad[l] = 30'(a + l);
            wd[l] = (a + l < 4) ? 32'hA0 + 32'(a + l) : $urandom;
            if (a + l == 8)  wd[l] = 32'h55;
            if (a + l == 20) wd[l] = 32'hFFFF_FFFF;
            be[l] = 4'hF; tg[l] = 8'h0;
         end
         do_batch(4'hF, 4'hF, be, ad, wd, tg, 0);
      end

      be = {4{4'hF}}; wd = '0;
      tg = {8'h13, 8'h12, 8'h11, 8'h10};
      do_batch(4'hF, 4'h0, be, {30'd3, 30'd2, 30'd1, 30'd0}, wd, tg, 0);
      do_batch(4'hF, 4'h0, be, {30'd8, 30'd8, 30'd8, 30'd8}, wd, {8'h24, 8'h23, 8'h22, 8'h21}, 0);
`ifdef SMEM_PERF_EN
      wait_drain();
      p0 = perf;
`endif
      do_batch(4'hF, 4'h0, be, {30'd12, 30'd8, 30'd4, 30'd0}, wd, {8'h34, 8'h33, 8'h32, 8'h31}, 0);
      wait_drain();
`ifdef SMEM_PERF_EN
      chk("perf_conflict", 64'(perf - p0), 64'd3);
`endif
      do_batch(4'b0101, 4'b0101, be, {30'd0, 30'd5, 30'd0, 30'd5},
               {32'h0, 32'h22, 32'h0, 32'h11}, tg, 0);
      do_batch(4'b0001, 4'b0000, be, {4{30'd5}}, wd, {8'h0, 8'h0, 8'h0, 8'h41}, 0);
      do_batch(4'b0001, 4'b0001, {4{4'b0011}}, {4{30'd20}}, {4{32'hDEAD_BEEF}}, tg, 0);
      do_batch(4'b0001, 4'b0000, be, {4{30'd20}}, wd, {8'h0, 8'h0, 8'h0, 8'h51}, 5);
      wait_drain();
      chk("bytemask_model", 64'(mem_m[20]), 64'hFFFF_BEEF);

      // Reset during the second access cycle of a conflicting write batch.
      wait_ready();
      bus.req_valid = 4'hF; bus.req_rw = 4'hF; bus.req_byteen = {4{4'hF}};
      bus.req_addr = {30'd12, 30'd8, 30'd4, 30'd0};
      bus.req_data = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
      @(negedge clk);
      bus.req_valid = 4'd0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midreset_req_ready", 64'(bus.req_ready), 64'hF);
      chk("midreset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      reset = 1'b0;
      mem_m[0] = 32'h1000;
      do_batch(4'hF, 4'h0, be, {30'd12, 30'd8, 30'd4, 30'd0}, wd, {8'h64, 8'h63, 8'h62, 8'h61}, 0);

      for (int i = 0; i < 40; i++) begin
         v  = 4'($urandom_range(1, 15));
         rw = 4'($urandom);
         for (int l = 0; l < 4; l++) begin
            ad[l] = 30'(($urandom << 12) | $urandom_range(0, 31));
            wd[l] = $urandom;
            be[l] = 4'($urandom);
            tg[l] = 8'($urandom);
         end
         do_batch(v, rw, be, ad, wd, tg, (i % 7 == 3) ? 2 : 0);
      end
      wait_drain();
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/smem_responder.md
Name: smem_responder

Overview:
- Responder end of the per-thread shared-memory request bus; accepts a batch of per-lane requests and services them against NUM_BANKS single-port word banks.
- Serializes bank conflicts and returns one merged read response: lane mask, per-lane data and tag.
- Sits behind the core data-bus split, on the shared-memory leg.
- Writes are fire-and-forget and produce no response.

Parameters:
- NUM_THREADS, 4, request/response lanes
- NUM_BANKS, 4, power of two, word-interleaved banks
- WORD_SIZE, 4, bytes per word
- SMEM_SIZE, 16384, total bytes; rows per bank = SMEM_SIZE/(WORD_SIZE*NUM_BANKS)
- ADDR_WIDTH, 30, word-address width of the incoming request
- TAG_WIDTH, 8, request/response tag width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_THREADS  per-lane request valid
- req_rw  in  NUM_THREADS  1=write
- req_byteen  in  NUM_THREADS*WORD_SIZE  per-lane byte enables
- req_addr  in  NUM_THREADS*ADDR_WIDTH  per-lane word address
- req_data  in  NUM_THREADS*WORD_SIZE*8  per-lane write data
- req_tag  in  NUM_THREADS*TAG_WIDTH  per-lane tag
- req_ready  out  NUM_THREADS  per-lane ready; all bits equal
- rsp_valid  out  NUM_THREADS  per-lane read-response valid mask
- rsp_data  out  NUM_THREADS*WORD_SIZE*8  per-lane read data
- rsp_tag  out  TAG_WIDTH  response tag
- rsp_ready  in  1  response accepted

Behaviour:
- Reset: state IDLE, pending mask 0, rsp_valid 0, rsp_data 0, rsp_tag 0, req_ready all 1 on the first cycle after reset. Bank contents are not reset.
- Address map: bank = addr[log2(NUM_BANKS)-1:0]; row = next log2(rows) bits; higher bits ignored.
- States: IDLE, SERVE, RSP.
- IDLE:
  - req_ready = all 1.
  - If any req_valid: latch all lane fields, set pending = req_valid, latch rd_mask = req_valid & ~req_rw, move to SERVE.
- SERVE, per bank, each cycle:
  - Pick the lowest-index pending lane mapped to that bank.
  - If that lane is a read, also serve every pending read lane with the same bank and row (broadcast merge).
  - If it is a write, serve only that lane, with a byte-masked write.
  - Clear the served lanes from pending.
  - Same-address writes therefore complete in ascending lane order; the highest lane's data persists.
- Bank read is synchronous: data is registered into that lane's rsp_data slot at the next edge.
- Leaving SERVE: when pending becomes 0 this cycle, go to RSP if rd_mask != 0, else go to IDLE.
- RSP:
  - rsp_valid = rd_mask.
  - rsp_tag = tag of the lowest-index set bit of rd_mask.
  - rsp_data for lanes outside rd_mask is don't-care but stable.
  - Hold all response outputs until rsp_ready; on the handshake go to IDLE and rsp_valid goes to 0.
- req_ready = 0 in SERVE and RSP; there is no overlap of the next batch with response hold.
- Latency:
  - Conflict-free read batch: accept at edge t, bank access in cycle t+1, rsp_valid visible in cycle t+2.
  - Each extra conflicting access adds 1 cycle.
  - Worst case is NUM_THREADS access cycles.
- A lane with byteen=0 and rw=1 is serviced as a no-op write that still occupies its bank for that cycle.
- Reset asserted mid-SERVE or mid-RSP: batch dropped, in-flight write of that cycle suppressed, state IDLE.

Optional Feature:
- Macro: SMEM_PERF_EN.
- With the macro defined:
  - Adds output perf_bank_stalls (44 bits), reset 0.
  - It increments by 1 for each SERVE cycle after the first cycle of a batch, i.e. each cycle caused by a conflict.
  - It wraps modulo 2^44.
- Without the macro: the port and counter are absent; functional behaviour is identical.

Decomposition:
- Shared package: state enum (IDLE/SERVE/RSP), bank/row select widths, and rows-per-bank as localparams derived from the parameters.
- One sub-module, smem_bank: single-port word RAM with byte-enable write and registered read, instantiated NUM_BANKS times.
- The lane-select/merge logic stays in the top module.

Test Plan:
- Conflict-free reads: lanes 0-3 read word addrs 0,1,2,3 after preloading 0xA0..0xA3 → rsp_valid=4'b1111 two cycles after accept, data 0xA0..0xA3, tag=lane0 tag.
- Broadcast: all 4 lanes read addr 8 (value 0x55) → single SERVE cycle, all lanes return 0x55.
- Conflict: lanes read addrs 0,4,8,12 (same bank 0) → 4 SERVE cycles, rsp_valid in cycle t+5; with SMEM_PERF_EN, counter +3.
- Write ordering: lanes 0 and 2 write addr 5 with 0x11 and 0x22, byteen=4'hF, then read addr 5 → 0x22; the write batch itself produces no rsp_valid.
- Byte-enable and backpressure: write 0xDEADBEEF with byteen=4'b0011 over 0xFFFFFFFF → read gives 0xFFFFBEEF; hold rsp_ready=0 for 5 cycles → outputs stable and req_ready=0 throughout.
- Reset in SERVE during a conflicting write batch → state IDLE, rsp_valid=0, req_ready=1 next cycle, suppressed write not visible on readback.
